bse_adc_frontend: RTL and testbench

// - Reads the brake system encoder (BSE) from an external 12-bit SPI ADC (mode 0), range-checks every sample and averages good ones.
// - Produces the filtered 12-bit BSE value consumed by the ready-to-drive / brake-light stage, plus a BSE sensor fault flag.
// - Sits between the ADC pins and RTDS; runs on the main FPGA clock.

---
 rtl/beowulf_pkg.sv | 6 +
 rtl/bse_adc_frontend_if.sv | 18 +
 rtl/bse_adc_frontend_rx.sv | 71 +++++++
 rtl/bse_adc_frontend.sv | 105 ++++++++++
 tb/tb_bse_adc_frontend.sv | 127 ++++++++++++
 5 files changed

// File: rtl/beowulf_pkg.sv
// beowulf_pkg: shared types and constants for the BSE ADC front end
package beowulf_pkg;
  typedef logic [11:0] adc12_t;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} bse_state_e;
  localparam int ADC_FRAME_BITS = 16;
endpackage

// File: rtl/bse_adc_frontend_if.sv
// bse_adc_frontend_if: ADC pins and filtered BSE outputs; bse_raw exists only with BSE_RAW_TAP_EN
interface bse_adc_frontend_if;
  import beowulf_pkg::*;
  logic adc_miso;
  logic adc_sclk;
  logic adc_cs_n;
  adc12_t bse;
  logic bse_valid;
  logic bse_fault;
`ifdef BSE_RAW_TAP_EN
  adc12_t bse_raw;
  modport master (input adc_miso, output adc_sclk, adc_cs_n, bse, bse_valid, bse_fault, bse_raw);
  modport slave (output adc_miso, input adc_sclk, adc_cs_n, bse, bse_valid, bse_fault, bse_raw);
`else
  modport master (input adc_miso, output adc_sclk, adc_cs_n, bse, bse_valid, bse_fault);
  modport slave (output adc_miso, input adc_sclk, adc_cs_n, bse, bse_valid, bse_fault);
`endif
endinterface

// File: rtl/bse_adc_frontend_rx.sv
// spi_adc_rx: sample timer, SPI mode-0 SCLK/CS generation and 16-bit MSB-first shifter
module spi_adc_rx
  import beowulf_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 5000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      miso,
  output logic                      sclk,
  output logic                      cs_n,
  output logic                      frame_done,
  output logic [ADC_FRAME_BITS-1:0] data
);
  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int DW = $clog2(CLK_DIV);
  localparam int HW = $clog2(2 * ADC_FRAME_BITS);
  bse_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] half_q, half_d;
  logic sclk_q, sclk_d;
  logic [ADC_FRAME_BITS-1:0] shift_q, shift_d;
  logic wrap, tick, busy;
  assign wrap = timer_q == TW'(SAMPLE_PERIOD - 1);
  assign tick = div_q == DW'(CLK_DIV - 1);
  assign busy = state_q inside {SETUP, SHIFT, HOLD};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      div_q   <= '0;
      half_q  <= '0;
      sclk_q  <= 1'b0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      div_q   <= div_d;
      half_q  <= half_d;
      sclk_q  <= sclk_d;
      shift_q <= shift_d;
    end
  end
  // a wrap outside IDLE is simply ignored
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = wrap ? SETUP : IDLE;
      SETUP:   state_d = tick ? SHIFT : SETUP;
      SHIFT:   state_d = tick && half_q == HW'(2 * ADC_FRAME_BITS - 1) ? HOLD : SHIFT;
      HOLD:    state_d = tick ? DONE : HOLD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    timer_d = wrap ? '0 : timer_q + 1'b1;
    div_d   = busy && !tick ? div_q + 1'b1 : '0;
    half_d  = state_q != SHIFT ? '0 : tick ? half_q + 1'b1 : half_q;
    sclk_d  = state_q == SHIFT && (tick ? !sclk_q : sclk_q);
    shift_d = state_q == SHIFT && tick && !sclk_q ? {shift_q[ADC_FRAME_BITS-2:0], miso} : shift_q;
  end
  always_comb begin
    cs_n       = !busy;
    sclk       = sclk_q;
    frame_done = state_q == DONE;
    data       = shift_q;
  end
endmodule

// File: rtl/bse_adc_frontend.sv
// bse_adc_frontend: BSE ADC read, range check, fault hysteresis and moving average
// Optional raw-code tap port bse_raw enabled by defining BSE_RAW_TAP_EN.
module bse_adc_frontend
  import beowulf_pkg::*;
#(
  parameter int     CLK_DIV       = 4,
  parameter int     SAMPLE_PERIOD = 5000,
  parameter int     AVG_LOG2      = 2,
  parameter adc12_t FAULT_LOW     = 12'd100,
  parameter adc12_t FAULT_HIGH    = 12'd3995,
  parameter int     FAULT_COUNT   = 3
) (
  input logic                  clk,
  input logic                  rst,
  bse_adc_frontend_if.master   io
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 12 + AVG_LOG2;
  localparam int PW    = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int FW    = AVG_LOG2 + 1;
  localparam int CW    = $clog2(FAULT_COUNT + 1);
  logic [ADC_FRAME_BITS-1:0] frame;
  logic frame_done;
  spi_adc_rx #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SAMPLE_PERIOD)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .miso       (io.adc_miso),
    .sclk       (io.adc_sclk),
    .cs_n       (io.adc_cs_n),
    .frame_done (frame_done),
    .data       (frame)
  );
  adc12_t raw;
  logic unused_frame_bits;
  assign raw = frame[12:1];
  assign unused_frame_bits = ^{frame[15:13], frame[0]};
  logic [CW-1:0] bad_cnt_q, bad_cnt_d, good_cnt_q, good_cnt_d, bad_inc, good_inc;
  logic fault_q, fault_d, valid_q, valid_d;
  adc12_t win_q [DEPTH];
  adc12_t win_d [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [SW-1:0] sum_q, sum_d;
  adc12_t bse_q, bse_d;
  logic bad, set_f, clr_f, take;
  assign bad      = raw < FAULT_LOW || raw > FAULT_HIGH;
  assign bad_inc  = bad_cnt_q == CW'(FAULT_COUNT) ? bad_cnt_q : bad_cnt_q + 1'b1;
  assign good_inc = good_cnt_q == CW'(FAULT_COUNT) ? good_cnt_q : good_cnt_q + 1'b1;
  assign set_f    = frame_done && bad && bad_inc == CW'(FAULT_COUNT);
  assign clr_f    = frame_done && !bad && good_inc == CW'(FAULT_COUNT);
  assign take     = frame_done && !bad;
  // unfilled window slots hold zero, so subtracting the evicted slot is always exact
  always_comb begin
    bad_cnt_d  = frame_done ? (bad ? bad_inc : '0) : bad_cnt_q;
    good_cnt_d = frame_done ? (bad ? '0 : good_inc) : good_cnt_q;
    fault_d    = set_f || (fault_q && !clr_f);
    win_d      = win_q;
    if (set_f)
      win_d = '{default: '0};
    else if (take)
      win_d[ptr_q] = raw;
    ptr_d   = set_f ? '0 : take ? (ptr_q == PW'(DEPTH - 1) ? '0 : ptr_q + 1'b1) : ptr_q;
    fill_d  = set_f ? '0 : take && fill_q != FW'(DEPTH) ? fill_q + 1'b1 : fill_q;
    sum_d   = set_f ? '0 : take ? sum_q - SW'(win_q[ptr_q]) + SW'(raw) : sum_q;
    valid_d = take && !fault_d && fill_d == FW'(DEPTH);
    bse_d   = frame_done && fault_d ? 12'hFFF : valid_d ? adc12_t'(sum_d >> AVG_LOG2) : bse_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_cnt_q  <= '0;
      good_cnt_q <= '0;
      fault_q    <= 1'b1;
      valid_q    <= 1'b0;
      win_q      <= '{default: '0};
      ptr_q      <= '0;
      fill_q     <= '0;
      sum_q      <= '0;
      bse_q      <= 12'hFFF;
    end else begin
      bad_cnt_q  <= bad_cnt_d;
      good_cnt_q <= good_cnt_d;
      fault_q    <= fault_d;
      valid_q    <= valid_d;
      win_q      <= win_d;
      ptr_q      <= ptr_d;
      fill_q     <= fill_d;
      sum_q      <= sum_d;
      bse_q      <= bse_d;
    end
  end
  assign io.bse       = bse_q;
  assign io.bse_valid = valid_q;
  assign io.bse_fault = fault_q;
`ifdef BSE_RAW_TAP_EN
  adc12_t raw_q, raw_d;
  assign raw_d = frame_done ? raw : raw_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      raw_q <= '0;
    else
      raw_q <= raw_d;
  end
  assign io.bse_raw = raw_q;
`endif
endmodule

// File: tb/tb_bse_adc_frontend.sv
// tb_bse_adc_frontend: directed checks of framing, hysteresis and averaging against an ADC model
module tb_bse_adc_frontend;
  import beowulf_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bse_adc_frontend_if bus ();
  bse_adc_frontend #(.CLK_DIV(2), .SAMPLE_PERIOD(200)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;
  // ADC model: mode 0, presents the next bit after every falling SCLK
  adc12_t code_r = '0;
  int idx = 0;
  logic prev_sclk = 1'b0;
  logic [15:0] frame_bits;
  always @(negedge clk) begin
    if (bus.adc_cs_n !== 1'b0)
      idx = 0;
    else if (prev_sclk === 1'b1 && bus.adc_sclk === 1'b0)
      idx++;
    prev_sclk = bus.adc_sclk;
    frame_bits = {3'b000, code_r, 1'b0};
    bus.adc_miso = idx < 16 ? frame_bits[15 - idx] : 1'b0;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  int wait_n, low_n, rise_n, start_cyc, last_start;
  task automatic do_frame(input adc12_t code);
    logic prev;
    code_r = code;
    wait_n = 0;
    while (bus.adc_cs_n !== 1'b0 && wait_n < 400) begin
      @(negedge clk);
      wait_n++;
    end
    check("frame_start_timeout", wait_n < 400, 1);
    last_start = start_cyc;
    start_cyc = cyc;
    low_n = 0;
    rise_n = 0;
    prev = bus.adc_sclk;
    while (bus.adc_cs_n === 1'b0 && low_n < 200) begin
      low_n++;
      @(negedge clk);
      if (bus.adc_sclk === 1'b1 && prev === 1'b0)
        rise_n++;
      prev = bus.adc_sclk;
    end
    check("sclk_idle_at_done", bus.adc_sclk, 0);
    @(negedge clk);
`ifdef BSE_RAW_TAP_EN
    check("bse_raw", bus.bse_raw, code);
`endif
  endtask
  int codes[18]  = '{1000, 1001, 1002, 1003, 100, 3995, 99, 3996, 2000, 50, 50, 50, 4090, 2000, 2000, 2000, 2000, 4090};
  int exp_bse[18] = '{1750, 1500, 1250, 1001, 776, 1525, 1525, 1525, 1774, 1774, 1774, 4095, 4095, 4095, 4095, 4095, 2000, 2000};
  int exp_val[18] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  int exp_flt[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
  initial begin
    repeat (3) @(negedge clk);
    check("rst_cs_n", bus.adc_cs_n, 1);
    check("rst_sclk", bus.adc_sclk, 0);
    check("rst_bse", bus.bse, 12'hFFF);
    check("rst_valid", bus.bse_valid, 0);
    check("rst_fault", bus.bse_fault, 1);
`ifdef BSE_RAW_TAP_EN
    check("rst_bse_raw", bus.bse_raw, 0);
`endif
    rst = 1'b0;
    do_frame(12'd2000);
    check("first_frame_delay", wait_n, 200);
    check("cs_low_cycles", low_n, 68);
    check("sclk_rises", rise_n, 16);
    check("f1_bse", bus.bse, 12'hFFF);
    check("f1_valid", bus.bse_valid, 0);
    check("f1_fault", bus.bse_fault, 1);
    do_frame(12'd2000);
    check("frame_interval", start_cyc - last_start, 200);
    check("f2_fault", bus.bse_fault, 1);
    do_frame(12'd2000);
    check("f3_fault", bus.bse_fault, 0);
    check("f3_bse", bus.bse, 12'hFFF);
    check("f3_valid", bus.bse_valid, 0);
    do_frame(12'd2000);
    check("f4_bse", bus.bse, 2000);
    check("f4_valid", bus.bse_valid, 1);
    check("f4_fault", bus.bse_fault, 0);
    @(negedge clk);
    check("valid_pulse_end", bus.bse_valid, 0);
    for (int i = 0; i < 18; i++) begin
      do_frame(adc12_t'(codes[i]));
      check($sformatf("bse[%0d]", i), bus.bse, exp_bse[i]);
      check($sformatf("valid[%0d]", i), bus.bse_valid, exp_val[i]);
      check($sformatf("fault[%0d]", i), bus.bse_fault, exp_flt[i]);
    end
    code_r = 12'd2000;
    wait_n = 0;
    while (!(bus.adc_cs_n === 1'b0 && bus.adc_sclk === 1'b1) && wait_n < 400) begin
      @(negedge clk);
      wait_n++;
    end
    check("shift_reached", wait_n < 400, 1);
    rst = 1'b1;
    #1;
    check("midrst_cs_n", bus.adc_cs_n, 1);
    check("midrst_sclk", bus.adc_sclk, 0);
    check("midrst_bse", bus.bse, 12'hFFF);
    check("midrst_fault", bus.bse_fault, 1);
    check("midrst_valid", bus.bse_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
